// File: rtl/ftch.sv
// ----------------------------------------------------------------------------
// ftch -- instruction fetch stage of the MIPS pipeline.
//
// Issues one sequential-PC request per cycle toward instruction memory,
// collects the in-order responses into a DEPTH-entry instruction queue and
// hands the queue head to decode over a valid/ready handshake. The imem
// channel has no ready, so issue is throttled by credits: every request in
// flight (kept or to be dropped) and every queued instruction holds one of
// DEPTH credits. A redirect from execute flushes the queue and turns every
// in-flight request into one whose response will be discarded.
//
// Ports
//   clk              in   clock
//   resetn           in   synchronous active-low reset
//   ftch_imem_vld    out  request valid (imem accepts every valid request)
//   ftch_imem_pkt    out  request packet, .pc = word-aligned fetch address
//   imem_ftch_vld    in   response valid (in order, fixed latency)
//   imem_ftch_instr  in   response instruction word
//   redirect_vld     in   redirect from execute
//   redirect_pc      in   redirect target, bits [1:0] ignored
//   ftch_dec_vld     out  queue head valid
//   ftch_dec_pc      out  PC of the queue head
//   ftch_dec_instr   out  instruction at the queue head
//   dec_ftch_rdy     in   decode accepts the head this cycle
// ----------------------------------------------------------------------------

package ftch_pkg;

    typedef struct packed {
        logic [31:0] pc;
    } ftch_imem_pkt_t;

endpackage

module ftch
    import ftch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic           clk,
    input  logic           resetn,
    output logic           ftch_imem_vld,
    output ftch_imem_pkt_t ftch_imem_pkt,
    input  logic           imem_ftch_vld,
    input  logic [31:0]    imem_ftch_instr,
    input  logic           redirect_vld,
    input  logic [31:0]    redirect_pc,
    output logic           ftch_dec_vld,
    output logic [31:0]    ftch_dec_pc,
    output logic [31:0]    ftch_dec_instr,
    input  logic           dec_ftch_rdy
);

    // Counter width holds 0..DEPTH; pointer width indexes 0..DEPTH-1.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Credit sum of three counters needs two extra bits of headroom.
    localparam int unsigned SW = CW + 2;

    // Circular pointer advance; works for DEPTH that is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_pc;          // next fetch address
    logic [CW-1:0] r_outst;       // responses owed and kept
    logic [CW-1:0] r_drop;        // responses owed and to be discarded
    logic [CW-1:0] r_count;       // valid instruction-queue entries
    logic [PW-1:0] r_head;        // instruction-queue read pointer
    logic [PW-1:0] r_tail;        // instruction-queue write pointer
    logic [PW-1:0] r_pend_rd;     // pending-PC FIFO read pointer
    logic [PW-1:0] r_pend_wr;     // pending-PC FIFO write pointer

    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_pend_pc [DEPTH];  // PCs of kept requests still in flight

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [SW-1:0] w_credit_used;
    logic          w_has_credit;
    logic          w_issue;
    logic          w_deq;
    logic          w_rsp_drop;
    logic          w_rsp_keep;
    logic          w_enq;
    logic          w_unused_rpc_lsbs;

    assign w_credit_used = SW'(r_outst) + SW'(r_drop) + SW'(r_count);
    assign w_has_credit  = (w_credit_used < SW'(DEPTH));

    // Issue is gated by reset and redirect combinationally so no request
    // leaves with a stale PC in the redirect cycle or while reset is held.
    assign ftch_imem_vld = resetn & ~redirect_vld & w_has_credit;
    assign ftch_imem_pkt = ftch_imem_pkt_t'{pc: r_pc};
    assign w_issue       = ftch_imem_vld;

    // Responses are in order, so any owed drops belong to the oldest
    // requests and are consumed before any kept response.
    assign w_rsp_drop = imem_ftch_vld & (r_drop != '0);
    assign w_rsp_keep = imem_ftch_vld & (r_drop == '0);
    assign w_enq      = w_rsp_keep & resetn & ~redirect_vld;

    assign w_deq = (r_count != '0) & dec_ftch_rdy;

    // Target is forced word-aligned; the low bits carry no information.
    assign w_unused_rpc_lsbs = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Pointers, counters and fetch PC
    // ------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_outst   <= '0;
            r_drop    <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
        end else if (redirect_vld) begin
            // Everything still owed becomes a drop; a response landing in
            // this very cycle is the oldest owed one and is discarded here.
            r_pc      <= {redirect_pc[31:2], 2'b00};
            r_drop    <= r_drop + r_outst - CW'(imem_ftch_vld);
            r_outst   <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
        end else begin
            if (w_issue) begin
                r_pc      <= r_pc + 32'd4;
                r_pend_wr <= ptr_inc(r_pend_wr);
            end
            if (w_rsp_keep) begin
                r_tail    <= ptr_inc(r_tail);
                r_pend_rd <= ptr_inc(r_pend_rd);
            end
            if (w_deq) begin
                r_head <= ptr_inc(r_head);
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_rsp_keep);
            r_drop  <= r_drop - CW'(w_rsp_drop);
            r_count <= r_count + CW'(w_rsp_keep) - CW'(w_deq);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: the storage arrays carry no reset; an entry is only ever read
    // while the counters say it holds data, and every such entry was written
    // after reset released.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend_pc[r_pend_wr] <= r_pc;
        end
        if (w_enq) begin
            r_q_pc[r_tail]    <= r_pend_pc[r_pend_rd];
            r_q_instr[r_tail] <= imem_ftch_instr;
        end
    end

    // ------------------------------------------------------------------
    // Decode outputs: register reads only, no path from rdy or redirect
    // ------------------------------------------------------------------
    assign ftch_dec_vld   = (r_count != '0);
    assign ftch_dec_pc    = r_q_pc[r_head];
    assign ftch_dec_instr = r_q_instr[r_head];

endmodule

// File: tb/tb_ftch.sv
// ----------------------------------------------------------------------------
// tb_ftch -- self-checking bench for ftch.
//
// An imem model with run-time latency answers every request the DUT issues.
// A queue-based behavioural model tracks requests in flight (each tagged
// kept/dropped) and the decode queue; a negedge process compares the DUT
// outputs against it every cycle. Directed scenarios add hand-computed
// literal expectations at chosen cycles.
// ----------------------------------------------------------------------------

module tb_ftch;

    import ftch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           ftch_imem_vld;
    ftch_imem_pkt_t ftch_imem_pkt;
    logic           imem_ftch_vld;
    logic [31:0]    imem_ftch_instr;
    logic           redirect_vld;
    logic [31:0]    redirect_pc;
    logic           ftch_dec_vld;
    logic [31:0]    ftch_dec_pc;
    logic [31:0]    ftch_dec_instr;
    logic           dec_ftch_rdy;

    ftch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ftch_imem_vld   (ftch_imem_vld),
        .ftch_imem_pkt   (ftch_imem_pkt),
        .imem_ftch_vld   (imem_ftch_vld),
        .imem_ftch_instr (imem_ftch_instr),
        .redirect_vld    (redirect_vld),
        .redirect_pc     (redirect_pc),
        .ftch_dec_vld    (ftch_dec_vld),
        .ftch_dec_pc     (ftch_dec_pc),
        .ftch_dec_instr  (ftch_dec_instr),
        .dec_ftch_rdy    (dec_ftch_rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        bit          keep;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    flight_t     infl[$];   // requests owed a response, oldest first
    entry_t      dq[$];     // instructions waiting for decode
    logic [31:0] m_pc;

    function automatic bit model_issue();
        return (resetn === 1'b1) && (redirect_vld === 1'b0) &&
               (infl.size() + dq.size() < DEPTH);
    endfunction

    // imem model state
    int          lat = 1;
    int          n_req = 0;
    bit          chk_en = 1'b0;
    logic        req_vld_s = 1'b0;
    logic [31:0] req_pc_s = '0;
    logic        pipe_v  [1:8];
    logic [31:0] pipe_pc [1:8];

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        req_vld_s = ftch_imem_vld;
        req_pc_s  = ftch_imem_pkt.pc;
        if (chk_en) begin
            check("imem_vld", {31'b0, ftch_imem_vld}, {31'b0, model_issue()});
            if (model_issue())
                check("imem_pc", ftch_imem_pkt.pc, m_pc);
            check("dec_vld", {31'b0, ftch_dec_vld}, {31'b0, dq.size() != 0});
            if (dq.size() != 0) begin
                check("dec_pc", ftch_dec_pc, dq[0].pc);
                check("dec_instr", ftch_dec_instr, dq[0].instr);
            end
        end
    end

    // Model state update and imem response generation at the clock edge.
    always @(posedge clk) begin
        bit      iss;
        flight_t f;
        if (resetn !== 1'b1) begin
            infl.delete();
            dq.delete();
            m_pc = RESET_PC;
            for (int k = 1; k <= 8; k++) begin
                pipe_v[k]  = 1'b0;
                pipe_pc[k] = '0;
            end
        end else begin
            iss = model_issue();
            if (dq.size() != 0 && dec_ftch_rdy)
                void'(dq.pop_front());
            if (imem_ftch_vld && infl.size() != 0) begin
                f = infl.pop_front();
                if (f.keep && !redirect_vld)
                    dq.push_back('{pc: f.pc, instr: imem_ftch_instr});
            end
            if (redirect_vld) begin
                foreach (infl[i]) infl[i].keep = 1'b0;
                dq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (iss) begin
                infl.push_back('{pc: m_pc, keep: 1'b1});
                m_pc = m_pc + 32'd4;
            end
            for (int k = 8; k > 1; k--) begin
                pipe_v[k]  = pipe_v[k-1];
                pipe_pc[k] = pipe_pc[k-1];
            end
            pipe_v[1]  = req_vld_s;
            pipe_pc[1] = req_pc_s;
            if (req_vld_s) n_req++;
        end
        #1;
        imem_ftch_vld   = pipe_v[lat];
        imem_ftch_instr = pipe_v[lat] ? instr_of(pipe_pc[lat]) : '0;
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    // Advance one cycle, drive inputs just after the edge, then settle.
    task automatic go(input logic rn, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        resetn       = rn;
        dec_ftch_rdy = rdy;
        redirect_vld = rd;
        redirect_pc  = rpc;
        #2;
    endtask

    initial begin
        resetn          = 1'b0;
        dec_ftch_rdy    = 1'b1;
        redirect_vld    = 1'b0;
        redirect_pc     = '0;
        imem_ftch_vld   = 1'b0;
        imem_ftch_instr = '0;

        // Reset state
        go(0, 1, 0, '0);
        chk_en = 1'b1;
        go(0, 1, 0, '0);
        check("rst_dec_vld", {31'b0, ftch_dec_vld}, 32'd0);
        check("rst_imem_vld", {31'b0, ftch_imem_vld}, 32'd0);
        check("rst_pkt_pc", ftch_imem_pkt.pc, 32'hBFC0_0000);

        // Stream, L=1, decode always ready
        go(1, 1, 0, '0);
        check("s_c0_vld", {31'b0, ftch_imem_vld}, 32'd1);
        check("s_c0_pc", ftch_imem_pkt.pc, 32'hBFC0_0000);
        go(1, 1, 0, '0);
        check("s_c1_pc", ftch_imem_pkt.pc, 32'hBFC0_0004);
        check("s_c1_dvld", {31'b0, ftch_dec_vld}, 32'd0);
        go(1, 1, 0, '0);
        check("s_c2_pc", ftch_imem_pkt.pc, 32'hBFC0_0008);
        check("s_c2_dvld", {31'b0, ftch_dec_vld}, 32'd1);
        check("s_c2_dpc", ftch_dec_pc, 32'hBFC0_0000);
        check("s_c2_instr", ftch_dec_instr, 32'h1357_241F);
        go(1, 1, 0, '0);
        check("s_c3_dpc", ftch_dec_pc, 32'hBFC0_0004);
        repeat (6) go(1, 1, 0, '0);

        // Backpressure, L=1, decode stalled
        go(0, 0, 0, '0);
        go(0, 0, 0, '0);
        n_req = 0;
        repeat (8) go(1, 0, 0, '0);
        check("bp_nreq", n_req, 32'd4);
        check("bp_vld", {31'b0, ftch_imem_vld}, 32'd0);
        check("bp_count", 32'(dut.r_count), 32'd4);
        check("bp_dpc", ftch_dec_pc, 32'hBFC0_0000);
        go(1, 1, 0, '0);
        check("bp_x_vld", {31'b0, ftch_imem_vld}, 32'd0);
        go(1, 0, 0, '0);
        check("bp_x1_vld", {31'b0, ftch_imem_vld}, 32'd1);
        check("bp_x1_pc", ftch_imem_pkt.pc, 32'hBFC0_0010);
        check("bp_x1_dpc", ftch_dec_pc, 32'hBFC0_0004);
        go(1, 0, 0, '0);
        check("bp_x2_vld", {31'b0, ftch_imem_vld}, 32'd0);
        repeat (3) go(1, 0, 0, '0);

        // Reset mid-stream with a full queue
        go(0, 0, 0, '0);
        check("mr_imem_vld", {31'b0, ftch_imem_vld}, 32'd0);
        lat = 3;
        go(0, 1, 0, '0);
        check("mr_dec_vld", {31'b0, ftch_dec_vld}, 32'd0);

        // Redirect with two responses in flight, L=3
        go(1, 1, 0, '0);
        check("mr_refetch_vld", {31'b0, ftch_imem_vld}, 32'd1);
        check("mr_refetch_pc", ftch_imem_pkt.pc, 32'hBFC0_0000);
        go(1, 1, 0, '0);
        check("rd_c1_pc", ftch_imem_pkt.pc, 32'hBFC0_0004);
        go(1, 1, 1, 32'h0000_1003);
        check("rd_c2_vld", {31'b0, ftch_imem_vld}, 32'd0);
        go(1, 1, 0, '0);
        check("rd_c3_pc", ftch_imem_pkt.pc, 32'h0000_1000);
        check("rd_c3_drop", 32'(dut.r_drop), 32'd2);
        go(1, 1, 0, '0);
        go(1, 1, 0, '0);
        go(1, 1, 0, '0);
        check("rd_c6_dvld", {31'b0, ftch_dec_vld}, 32'd0);
        go(1, 1, 0, '0);
        check("rd_c7_dvld", {31'b0, ftch_dec_vld}, 32'd1);
        check("rd_c7_dpc", ftch_dec_pc, 32'h0000_1000);
        repeat (4) go(1, 1, 0, '0);

        // Redirect colliding with a response and a decode handshake, L=3
        go(0, 1, 0, '0);
        go(0, 1, 0, '0);
        repeat (5) go(1, 1, 0, '0);
        go(1, 1, 1, 32'h0000_2000);
        check("col_dvld", {31'b0, ftch_dec_vld}, 32'd1);
        check("col_dpc", ftch_dec_pc, 32'hBFC0_0004);
        check("col_vld", {31'b0, ftch_imem_vld}, 32'd0);
        go(1, 1, 0, '0);
        check("col_drop", 32'(dut.r_drop), 32'd1);
        check("col_empty", {31'b0, ftch_dec_vld}, 32'd0);
        check("col_pc", ftch_imem_pkt.pc, 32'h0000_2000);
        repeat (8) go(1, 1, 0, '0);

        // Address wrap, L=1
        go(0, 1, 0, '0);
        lat = 1;
        go(0, 1, 0, '0);
        repeat (3) go(1, 1, 0, '0);
        go(1, 1, 1, 32'hFFFF_FFF8);
        check("wr_c3_vld", {31'b0, ftch_imem_vld}, 32'd0);
        go(1, 1, 0, '0);
        check("wr_c4_pc", ftch_imem_pkt.pc, 32'hFFFF_FFF8);
        go(1, 1, 0, '0);
        check("wr_c5_pc", ftch_imem_pkt.pc, 32'hFFFF_FFFC);
        go(1, 1, 0, '0);
        check("wr_c6_pc", ftch_imem_pkt.pc, 32'h0000_0000);
        check("wr_c6_dpc", ftch_dec_pc, 32'hFFFF_FFF8);
        repeat (4) go(1, 1, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
